// File: rtl/uivtc_pip_mixer.sv
// PiP mixer: composes RGB888 from timing-generator strobes, background colour and
// the PiP frame-buffer FIFO; owns the FIFO read side and its once-per-frame flush.
module uivtc_pip_mixer #(
  parameter logic [23:0] BG_COLOR     = 24'h202020,
  parameter logic [23:0] UFLOW_COLOR  = 24'hFF00FF,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter bit          RESYNC_EVERY = 1'b1
) (
  input  logic        I_vtc_clk,
  input  logic        I_vtc_rstn,
  input  logic        I_vs,
  input  logic        I_hs,
  input  logic        I_de,
  input  logic        I_win_de,
  output logic        O_fifo_rd,
  input  logic [23:0] I_fifo_dout,
  input  logic        I_fifo_empty,
  output logic        O_fifo_rst,
  output logic        O_vs,
  output logic        O_hs,
  output logic        O_de,
  output logic [23:0] O_rgb,
  output logic        O_frame_start,
  output logic [15:0] O_uflow_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT, S_ACTIVE} state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] flush_cnt, flush_cnt_nxt;
  logic        vs_q, vs_rise, reading, uflow;
  logic        vs1, hs1, de1, win1, rd1, uflow1;
  logic        de_seen;

  assign vs_rise   = I_vs & ~vs_q;
  assign reading   = (state == S_ACTIVE) | ((state == S_WAIT) & I_de);
  assign O_fifo_rd = I_win_de & ~I_fifo_empty & reading;
  assign uflow     = I_win_de & ~O_fifo_rd & reading;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      S_IDLE: begin
        if (vs_rise) begin
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      S_FLUSH: begin
        if (vs_rise)
          flush_cnt_nxt = '0;
        else if (flush_cnt == FLUSH_LAST)
          state_nxt = S_WAIT;
        else
          flush_cnt_nxt = flush_cnt + 16'd1;
      end
      S_WAIT: begin
        if (I_de) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (RESYNC_EVERY && vs_rise) begin
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // O_fifo_rst is the registered image of the FLUSH state, so it spans exactly the flush count
  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      state      <= S_IDLE;
      flush_cnt  <= '0;
      vs_q       <= 1'b0;
      O_fifo_rst <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      vs_q       <= I_vs;
      O_fifo_rst <= (state_nxt == S_FLUSH);
    end
  end

  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      vs1    <= 1'b0;
      hs1    <= 1'b0;
      de1    <= 1'b0;
      win1   <= 1'b0;
      rd1    <= 1'b0;
      uflow1 <= 1'b0;
    end else begin
      vs1    <= I_vs;
      hs1    <= I_hs;
      de1    <= I_de;
      win1   <= I_win_de;
      rd1    <= O_fifo_rd;
      uflow1 <= uflow;
    end
  end

  // FIFO data lands one clock after the read strobe, i.e. alongside the stage-1 flags
  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      O_vs          <= 1'b0;
      O_hs          <= 1'b0;
      O_de          <= 1'b0;
      O_rgb         <= '0;
      O_frame_start <= 1'b0;
      O_uflow_cnt   <= '0;
      de_seen       <= 1'b0;
    end else begin
      O_vs          <= vs1;
      O_hs          <= hs1;
      O_de          <= de1;
      O_frame_start <= de1 & ~de_seen;
      de_seen       <= vs_rise ? 1'b0 : (de_seen | de1);
      if (!de1)
        O_rgb <= '0;
      else if (win1 && rd1)
        O_rgb <= I_fifo_dout;
      else if (win1 && uflow1)
        O_rgb <= UFLOW_COLOR;
      else
        O_rgb <= BG_COLOR;
      if (uflow1 && (O_uflow_cnt != '1))
        O_uflow_cnt <= O_uflow_cnt + 16'd1;
    end
  end

endmodule
